spi_flash_responder: RTL and testbench
======================================

// Module: spi_flash_responder
// PURPOSE
//  Synthesizable SPI flash target (mode 0, single I/O). It answers the management SoC flash master on
//  flash_csb/flash_clk/flash_io0/flash_io1. Read data comes from an on-chip memory port.
//  Used as a boot-ROM emulator on FPGA prototypes and in chip-level simulation in place of an external flash.
//  SPI pins are oversampled in the system clock domain; no logic is clocked by flash_clk.
// PARAMETERS
//  ADDR_W     16         memory word address width; byte address wraps modulo 2**ADDR_W
//  JEDEC_ID   24'hEF4016 3 bytes returned by opcode 0x9F, MSB byte first
//  STATUS_VAL 8'h00      byte returned (repeatedly) by opcode 0x05
// PORTS
//  clock         in   1       system clock; must be >= 4x flash_clk frequency
//  reset         in   1       asynchronous, active-high reset
//  flash_csb     in   1       chip select, active low (async to clock)
//  flash_clk     in   1       SPI clock (async to clock)
//  flash_io0     in   1       MOSI (async to clock)
//  flash_io1_do  out  1       MISO data
//  flash_io1_oe  out  1       MISO output enable; high only while shifting response bits
//  mem_addr      out  ADDR_W  byte address to memory
//  mem_rd        out  1       one-cycle read strobe
//  mem_rdata     in   8       read data, valid exactly 1 cycle after mem_rd
//  busy          out  1       high while a transaction is active (synced csb low)
//  cmd_err       out  1       one-cycle pulse when an unsupported opcode completes
// BEHAVIOUR
//  - Reset values: flash_io1_do=0, flash_io1_oe=0, mem_addr=0, mem_rd=0, busy=0, cmd_err=0, state=IDLE.
//  - Inputs pass through 2-flop synchronizers. Edge detect runs on the synced flash_clk:
//    rise = sample io0 into the shift register; fall = shift out the next MISO bit. Data is MSB first.
//  - csb rising (synced), at any state or bit count: go to IDLE next cycle, drop oe, clear bit counters.
//    Partial bytes are discarded.
//  - csb falling: go to CMD, bit_cnt=0, busy=1. Clock edges seen while csb is high are ignored.
//  - CMD: after 8 rising edges, decode the opcode:
//      0x03 -> ADDR
//      0x9F -> ID (load byte JEDEC_ID[23:16])
//      0x05 -> STATUS (load STATUS_VAL)
//      0xAB -> IGNORE (no response, no cmd_err)
//      other -> IGNORE with cmd_err pulse.
//  - ADDR: shift in 24 bits. Use the low ADDR_W bits as mem_addr; drop the upper bits silently.
//    On the 24th rise, assert mem_rd; capture mem_rdata into tx_byte on the next cycle; go to DATA.
//  - DATA/ID/STATUS: flash_io1_oe=1 from the first fall after entering the state.
//    Each fall drives tx_byte[7-bit_cnt] on flash_io1_do.
//    On the 8th fall of a byte:
//      DATA: mem_addr+1 (wraps 2**ADDR_W-1 -> 0), and mem_rd is issued on the same cycle.
//      ID: next JEDEC byte; after byte 3, output 0x00.
//      STATUS: repeat STATUS_VAL.
//  - Latency: mem_rd -> tx_byte load is 1 cycle. The 4x oversampling ratio guarantees the load
//    completes before the next fall.
//  - IGNORE: oe=0, consume edges until csb rises.
//  - Simultaneous csb rise and clk edge in the same cycle: csb wins, and the edge is dropped.
//  - Reset mid-transaction: immediate return to reset values; the next csb fall starts a fresh command.
// STRUCTURE
//  - spi_flash_pkg: opcode localparams (OP_READ=8'h03, OP_RDID=8'h9F, OP_RDSR=8'h05, OP_RES=8'hAB)
//    and state typedef {IDLE, CMD, ADDR, DATA, ID, STATUS, IGNORE}.
//  - Sub-module flash_pin_sync: 2-flop synchronizers for csb/clk/io0, plus rise/fall pulse outputs.
//  - Top holds the FSM, the bit/byte counters, the shift registers and the address counter.
// TESTING
//  1. Reset with csb=1 -> all outputs 0, busy=0, oe=0.
//  2. READ: send 03 00 00 10, clock 3 bytes, memory holds [0x10]=A5,[0x11]=3C,[0x12]=FF
//     -> MISO bytes A5,3C,FF; mem_rd pulses at 0x10,0x11,0x12,0x13.
//  3. READ at 0xFFFF (ADDR_W=16), clock 2 bytes -> bytes from 0xFFFF then 0x0000; addr bits 23:16=0x7F ignored.
//  4. 9F then 4 bytes -> EF,40,16,00. 05 then 2 bytes -> 00,00.
//  5. Opcode 0x42 -> single cmd_err pulse, oe stays 0. Opcode 0xAB -> no cmd_err, oe stays 0.
//  6. csb raised after 13 address bits, then a READ of 0x000020 -> oe drops within 3 cycles;
//     the new read returns [0x20]. Assert reset mid-DATA -> outputs at reset values on the same cycle.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash responder: opcodes, FSM states, ID byte helper.
// Latency: none (definitions only).
// Backpressure: not applicable.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_RES  = 8'hAB;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        ID,
        STATUS,
        IGNORE
    } state_t;

    // Byte idx of the 3-byte JEDEC ID, MSB byte first; anything past the third byte reads as zero.
    function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        case (idx)
            2'd0:    id_byte = id[23:16];
            2'd1:    id_byte = id[15:8];
            2'd2:    id_byte = id[7:0];
            default: id_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/flash_pin_sync.sv
// Brings the asynchronous SPI pins into the system clock domain and flags their edges.
// Latency: 2 cycles to the synced level, edge pulses in the cycle the synced level changes.
// Backpressure: none; pins are sampled every cycle.
module flash_pin_sync (
    input  logic clock,
    input  logic reset,
    input  logic csb_in,
    input  logic clk_in,
    input  logic io0_in,
    output logic io0,
    output logic clk_rise,
    output logic clk_fall,
    output logic csb_rise,
    output logic csb_fall
);

    // [0],[1] are the synchronizer pair, [2] is the previous synced value for edge detection.
    logic [2:0] csb_q;
    logic [2:0] clk_q;
    logic [1:0] io0_q;

    // Synchronizer and edge-history registers; csb resets high so reset never looks like a select.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            csb_q <= 3'b111;
            clk_q <= 3'b000;
            io0_q <= 2'b00;
        end else begin
            csb_q <= {csb_q[1:0], csb_in};
            clk_q <= {clk_q[1:0], clk_in};
            io0_q <= {io0_q[0], io0_in};
        end
    end

    // io0 goes through the same depth as clk so it is aligned with clk_rise.
    assign io0      = io0_q[1];
    assign clk_rise =  clk_q[1] & ~clk_q[2];
    assign clk_fall = ~clk_q[1] &  clk_q[2];
    assign csb_rise =  csb_q[1] & ~csb_q[2];
    assign csb_fall = ~csb_q[1] &  csb_q[2];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target answering READ/RDID/RDSR from an on-chip memory port.
// Latency: pins seen 2 cycles late; mem_rd to tx_byte is 1 cycle, first data bit bypasses the load.
// Backpressure: none; the system clock must run at least 4x flash_clk.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_W     = 16,   // must be at least 9
    parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flash_csb,
    input  logic              flash_clk,
    input  logic              flash_io0,
    output logic              flash_io1_do,
    output logic              flash_io1_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    logic              io0_s, clk_rise, clk_fall, csb_rise, csb_fall;
    state_t            state, state_next;
    logic [4:0]        bit_cnt;
    // Only the low ADDR_W bits of the address ever matter, so older bits simply fall off the top.
    logic [ADDR_W-2:0] shift_in;
    logic [ADDR_W-1:0] shift_nx;
    logic [7:0]        tx_byte;
    logic [1:0]        id_idx;
    logic              rd_d;
    logic              last_rise;
    logic [2:0]        bit_sel;
    logic              tx_bit;
    logic              tx_state;

    flash_pin_sync u_sync (
        .clock    (clock),
        .reset    (reset),
        .csb_in   (flash_csb),
        .clk_in   (flash_clk),
        .io0_in   (flash_io0),
        .io0      (io0_s),
        .clk_rise (clk_rise),
        .clk_fall (clk_fall),
        .csb_rise (csb_rise),
        .csb_fall (csb_fall)
    );

    assign shift_nx  = {shift_in, io0_s};
    assign last_rise = clk_rise && ((state == CMD  && bit_cnt == 5'd7) ||
                                    (state == ADDR && bit_cnt == 5'd23));
    assign tx_state  = (state == DATA) || (state == ID) || (state == STATUS);
    assign bit_sel   = 3'd7 - bit_cnt[2:0];
    // While a fresh memory byte is still being loaded, take the bit straight from the memory port.
    assign tx_bit    = rd_d ? mem_rdata[bit_sel] : tx_byte[bit_sel];
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: csb edges override everything, otherwise opcode and address completion advance.
    always_comb begin
        state_next = state;
        if (csb_rise) begin
            state_next = IDLE;
        end else if (csb_fall) begin
            state_next = CMD;
        end else begin
            case (state)
                CMD: if (last_rise) begin
                    case (shift_nx[7:0])
                        OP_READ: state_next = ADDR;
                        OP_RDID: state_next = ID;
                        OP_RDSR: state_next = STATUS;
                        default: state_next = IGNORE;
                    endcase
                end
                ADDR: if (last_rise) state_next = DATA;
                default: state_next = state;
            endcase
        end
    end

    // Datapath: shift in on rises, shift out on falls, advance address/ID bytes at byte boundaries.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flash_io1_do <= 1'b0;
            flash_io1_oe <= 1'b0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            cmd_err      <= 1'b0;
            bit_cnt      <= '0;
            shift_in     <= '0;
            tx_byte      <= '0;
            id_idx       <= '0;
            rd_d         <= 1'b0;
        end else begin
            mem_rd  <= 1'b0;
            cmd_err <= 1'b0;
            rd_d    <= mem_rd;
            if (rd_d) tx_byte <= mem_rdata;

            if (csb_rise || csb_fall) begin
                // A csb edge drops any clock edge in the same cycle and discards partial bytes.
                bit_cnt      <= '0;
                flash_io1_oe <= 1'b0;
                flash_io1_do <= 1'b0;
            end else if (clk_rise && (state == CMD || state == ADDR)) begin
                shift_in <= shift_nx[ADDR_W-2:0];
                bit_cnt  <= last_rise ? 5'd0 : bit_cnt + 5'd1;
                if (last_rise && state == CMD) begin
                    case (shift_nx[7:0])
                        OP_RDID: begin
                            tx_byte <= id_byte(JEDEC_ID, 2'd0);
                            id_idx  <= 2'd1;
                        end
                        OP_RDSR: tx_byte <= STATUS_VAL;
                        OP_READ, OP_RES: ;
                        default: cmd_err <= 1'b1;
                    endcase
                end
                if (last_rise && state == ADDR) begin
                    mem_addr <= shift_nx;
                    mem_rd   <= 1'b1;
                end
            end else if (clk_fall && tx_state) begin
                flash_io1_oe <= 1'b1;
                flash_io1_do <= tx_bit;
                bit_cnt      <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
                if (bit_cnt == 5'd7) begin
                    if (state == DATA) begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        mem_rd   <= 1'b1;
                    end else if (state == ID) begin
                        tx_byte <= id_byte(JEDEC_ID, id_idx);
                        if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
module tb_spi_flash_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flash_csb = 1'b1;
    logic        flash_clk = 1'b0;
    logic        flash_io0 = 1'b0;
    logic        flash_io1_do, flash_io1_oe, mem_rd, busy, cmd_err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:65535];
    logic [7:0]  exp_bytes [$];
    logic [15:0] exp_addrs [$];
    int          err_pulses = 0;
    bit          oe_seen = 1'b0;
    int          nbits = 0;
    logic [7:0]  acc = 8'h00;

    always #5 clock = ~clock;

    spi_flash_responder dut (
        .clock        (clock),
        .reset        (reset),
        .flash_csb    (flash_csb),
        .flash_clk    (flash_clk),
        .flash_io0    (flash_io0),
        .flash_io1_do (flash_io1_do),
        .flash_io1_oe (flash_io1_oe),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .cmd_err      (cmd_err)
    );

    // Memory model: data valid the cycle after the strobe.
    always @(posedge clock) if (mem_rd) mem_rdata <= mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: memory read strobes, cmd_err pulses, any oe activity.
    always @(negedge clock) begin
        if (cmd_err) err_pulses++;
        if (flash_io1_oe) oe_seen = 1'b1;
        if (mem_rd) begin
            if (exp_addrs.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_rd_unexpected: got addr %0h expected no read", mem_addr);
            end else begin
                check("mem_rd_addr", {16'h0, mem_addr}, {16'h0, exp_addrs.pop_front()});
            end
        end
    end

    // Monitor: assemble MISO bytes as the master would sample them on flash_clk rising.
    always @(posedge flash_clk or posedge flash_csb) begin
        if (flash_csb) begin
            nbits = 0;
        end else if (flash_io1_oe) begin
            acc = {acc[6:0], flash_io1_do};
            nbits++;
            if (nbits == 8) begin
                nbits = 0;
                if (exp_bytes.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL miso_unexpected: got byte %0h expected none", acc);
                end else begin
                    check("miso_byte", {24'h0, acc}, {24'h0, exp_bytes.pop_front()});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic spi_bit(input logic b);
        flash_io0 = b;
        repeat (8) @(negedge clock);
        flash_clk = 1'b1;
        repeat (8) @(negedge clock);
        flash_clk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic cs_low();
        @(negedge clock);
        flash_csb = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clock);
        flash_csb = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    task automatic check_drained(input string name);
        check({name, "_bytes_left"}, exp_bytes.size(), 0);
        check({name, "_reads_left"}, exp_addrs.size(), 0);
    endtask

    initial begin
        int n;
        int base;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'hA5;
        mem[16'h0011] = 8'h3C;
        mem[16'h0012] = 8'hFF;
        mem[16'hFFFF] = 8'h81;
        mem[16'h0000] = 8'h7E;
        mem[16'h0020] = 8'hC3;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_oe", flash_io1_oe, 0);
        check("rst_do", flash_io1_do, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_rd", mem_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_err", cmd_err, 0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("idle_busy", busy, 0);

        // READ 0x000010, three bytes
        exp_addrs = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
        exp_bytes = '{8'hA5, 8'h3C, 8'hFF};
        cs_low();
        check("busy_active", busy, 1);
        spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h10);
        repeat (3) spi_byte(8'h00);
        cs_high();
        check("busy_after_read", busy, 0);
        check_drained("read");

        // READ at top of memory, upper address byte ignored
        exp_addrs = '{16'hFFFF, 16'h0000, 16'h0001};
        exp_bytes = '{8'h81, 8'h7E};
        cs_low();
        spi_byte(8'h03); spi_byte(8'h7F); spi_byte(8'hFF); spi_byte(8'hFF);
        repeat (2) spi_byte(8'h00);
        cs_high();
        check_drained("wrap");

        // JEDEC ID
        exp_bytes = '{8'hEF, 8'h40, 8'h16, 8'h00};
        cs_low();
        spi_byte(8'h9F);
        repeat (4) spi_byte(8'h00);
        cs_high();
        check_drained("rdid");

        // Status
        exp_bytes = '{8'h00, 8'h00};
        cs_low();
        spi_byte(8'h05);
        repeat (2) spi_byte(8'h00);
        cs_high();
        check_drained("rdsr");

        // Unsupported opcode
        base = err_pulses;
        oe_seen = 1'b0;
        cs_low();
        spi_byte(8'h42); spi_byte(8'h00);
        cs_high();
        check("bad_op_err_pulses", err_pulses - base, 1);
        check("bad_op_oe", oe_seen, 0);

        // Release from deep power-down: silently ignored
        base = err_pulses;
        oe_seen = 1'b0;
        cs_low();
        spi_byte(8'hAB); spi_byte(8'h00);
        cs_high();
        check("res_err_pulses", err_pulses - base, 0);
        check("res_oe", oe_seen, 0);

        // Abort after 13 address bits
        cs_low();
        spi_byte(8'h03);
        for (int i = 0; i < 13; i++) spi_bit(1'b1);
        flash_csb = 1'b1;
        n = 0;
        while (busy && n < 6) begin @(negedge clock); n++; end
        check("abort_addr_busy", busy, 0);
        repeat (8) @(negedge clock);

        exp_addrs = '{16'h0020, 16'h0021};
        exp_bytes = '{8'hC3};
        cs_low();
        spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h20);
        spi_byte(8'h00);
        cs_high();
        check_drained("after_abort");

        // Abort mid-byte in DATA: oe must drop quickly
        exp_addrs = '{16'h0010};
        cs_low();
        spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h10);
        for (int i = 0; i < 3; i++) spi_bit(1'b0);
        check("data_oe_on", flash_io1_oe, 1);
        flash_csb = 1'b1;
        n = 0;
        while (flash_io1_oe && n < 10) begin @(negedge clock); n++; end
        check("abort_oe_within_3", (n <= 3), 1);
        repeat (8) @(negedge clock);
        check_drained("abort_data");

        // Reset mid-DATA
        exp_addrs = '{16'h0010};
        cs_low();
        spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h10);
        for (int i = 0; i < 4; i++) spi_bit(1'b0);
        reset = 1'b1;
        #1;
        check("midrst_oe", flash_io1_oe, 0);
        check("midrst_do", flash_io1_do, 0);
        check("midrst_addr", mem_addr, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rd", mem_rd, 0);
        check("midrst_err", cmd_err, 0);
        @(negedge clock);
        flash_csb = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        exp_bytes = '{8'hEF};
        cs_low();
        spi_byte(8'h9F); spi_byte(8'h00);
        cs_high();
        check_drained("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
